rv_multi_cycle_core: RTL and testbench
======================================

Name: rv_multi_cycle_core

Overview:
Parametrised multi-cycle RV32I-subset core, the successor to the single-cycle top. It has one unified memory port with a req/ready handshake, so it tolerates wait-state memories and shares a single memory for instructions and data. An internal FSM sequences fetch, decode, execute, memory and writeback, and reuses one ALU across all cycles. It exposes retire and illegal-instruction strobes for the verification bench.

Parameters:
XLEN, 32, datapath/register/address width (instruction word fixed 32 bits; XLEN >= 32)
NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E); regfile index width = clog2(NREGS)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read; valid with mem_req
mem_addr  output  XLEN  byte address, word access only
mem_wdata  output  XLEN  store data
mem_ready  input  1  memory accepts/completes request this cycle
mem_rdata  input  XLEN  read data, valid when mem_req & mem_ready & !mem_we
instr_retired  output  1  one-cycle pulse in the final cycle of each instruction
halted  output  1  core stopped
illegal  output  1  sticky; set with halted on unsupported encoding

Behaviour:
- Reset (async, active-high): state=FETCH, PC=RESET_PC, all regs=0, IR=0, halted=0, illegal=0, instr_retired=0. mem_req drops immediately, including mid-transaction; the memory must tolerate abandonment.
- Supported: lw, sw; R-type add/sub/and/or/slt; I-type addi/andi/ori/slti; beq; jal. Anything else, or a supported opcode with an unsupported funct3/funct7 -> HALT.
- x0 reads 0; writes to x0 are discarded. Register fields >= NREGS are illegal.
- ALU ops: add, sub, and, or, slt (signed). All arithmetic is XLEN-bit wrap-around; immediates are sign-extended to XLEN.
- Handshake: the transfer completes on the rising edge where mem_req & mem_ready. Until then mem_req, mem_we, mem_addr and mem_wdata are held stable. mem_req is a function of state only, never of mem_ready.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready, IR <= mem_rdata -> DECODE.
  - DECODE: latch A=rs1, B=rs2, imm, and target=PC+imm. Illegal -> HALT; else -> EXECUTE.
  - EXECUTE: ALU on A and (B or imm).
    - R/I -> WB.
    - lw/sw: addr=A+imm -> MEM.
    - beq: PC <= (A==B) ? target : PC+4; retire -> FETCH.
    - jal: rd <= PC+4, PC <= target; retire -> FETCH.
  - MEM: mem_req=1, mem_addr=addr. sw: mem_we=1, mem_wdata=B; on ready, PC+=4, retire -> FETCH. lw: on ready, MDR <= mem_rdata -> WB.
  - WB: rd <= ALU result or MDR; PC+=4; retire -> FETCH.
  - HALT: absorbing; mem_req=0, halted=1. Only reset exits.
- Latency with zero-wait memory (ready in the request cycle): beq/jal 3 cycles, R/I/sw 4, lw 5. Each memory wait cycle adds exactly 1.
- The PC holds the address of the current instruction until retire; PC[1:0] is not checked.

Decomposition:
- Package rv_core_pkg: opcode constants (LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011, JAL 1101111); the 3-bit ALU control encoding (000 add, 001 sub, 010 and, 011 or, 101 slt); the FSM state enum; the immediate-format enum (I, S, B, J).
- One sub-module, rv_regfile_mc: 2 async-read ports, 1 sync-write port, async reset, parametrised by XLEN and NREGS. The ALU and immediate generator stay inline.

Test Plan:
- Reset: hold rst, release. -> FETCH with mem_req=1, mem_addr=0. Asserting rst mid-MEM drops mem_req the same cycle, and the next fetch is from 0.
- Zero-wait program 0x00500093 (addi x1,x0,5), 0x00108133 (add x2,x1,x1). -> instr_retired pulses at cycles 4 and 8 after reset release; x2=10.
- Continue with 0x00202423 (sw x2,8(x0)). -> mem_we=1, mem_addr=8, mem_wdata=10. Then 0x00802183 (lw x3,8(x0)), with memory returning 10 -> x3=10, retire 5 cycles after the sw retire.
- Wait states: mem_ready=0 for 3 cycles during a fetch and during a lw MEM. -> address and control held stable; each instruction retires exactly 3 cycles later than zero-wait.
- Branch: 0xFE108EE3 (beq x1,x1,-4) at PC=0x10. -> next fetch at 0x0C; with x1!=x2 in beq x1,x2 the next fetch is at 0x14.
- Illegal: fetch 0x00000000. -> halted=1 and illegal=1 after DECODE, no further mem_req and no retire, until rst.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, ALU control,
// FSM states and immediate formats.
package rv_core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_fmt_t;

endpackage

// File: rtl/rv_regfile_mc.sv
// Architectural register file: two combinational read ports, one clocked
// write port; x0 is hardwired to zero.
module rv_regfile_mc #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/rv_multi_cycle_core.sv
// Multi-cycle RV32I-subset core with a single shared req/ready memory port;
// one FSM sequences fetch/decode/execute/mem/writeback around one ALU.
module rv_multi_cycle_core
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_retired,
  output logic            halted,
  output logic            illegal
);

  localparam int AW = $clog2(NREGS);

  state_t          state;
  logic [XLEN-1:0] pc, a_q, b_q, imm_q, target_q, addr_q, mdr_q, alu_q;
  logic [31:0]     ir;
  logic            halted_q, illegal_q;

  logic [6:0]      opcode, funct7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [2:0]      funct3;
  imm_fmt_t        imm_fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_val, rs1_data, rs2_data, alu_b, alu_y, rf_wdata;
  alu_ctrl_t       alu_ctrl;
  logic            op_ok, regs_ok, legal, rf_we;

  assign opcode = ir[6:0];
  assign rd_f   = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1_f  = ir[19:15];
  assign rs2_f  = ir[24:20];
  assign funct7 = ir[31:25];

  always_comb begin
    case (opcode)
      OPC_STORE:  imm_fmt = IMM_S;
      OPC_BRANCH: imm_fmt = IMM_B;
      OPC_JAL:    imm_fmt = IMM_J;
      default:    imm_fmt = IMM_I;
    endcase
    case (imm_fmt)
      IMM_S:   imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign imm_val = XLEN'($signed(imm32));

  always_comb begin
    case (opcode)
      OPC_OP:     op_ok = (funct7 == 7'h00 && (funct3 == 3'd0 || funct3 == 3'd2 ||
                                               funct3 == 3'd6 || funct3 == 3'd7)) ||
                          (funct7 == 7'h20 && funct3 == 3'd0);
      OPC_OP_IMM: op_ok = (funct3 == 3'd0 || funct3 == 3'd2 ||
                           funct3 == 3'd6 || funct3 == 3'd7);
      OPC_LOAD,
      OPC_STORE:  op_ok = (funct3 == 3'd2);
      OPC_BRANCH: op_ok = (funct3 == 3'd0);
      OPC_JAL:    op_ok = 1'b1;
      default:    op_ok = 1'b0;
    endcase
  end

  // Only fields the format actually uses as register numbers are range-checked.
  if (NREGS >= 32) begin : g_full_regs
    assign regs_ok = 1'b1;
  end else begin : g_part_regs
    logic use_rs1, use_rs2, use_rd;
    assign use_rs1 = (opcode != OPC_JAL);
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign use_rd  = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) ||
                     (opcode == OPC_LOAD) || (opcode == OPC_JAL);
    assign regs_ok = !(use_rs1 && rs1_f >= 5'(NREGS)) &&
                     !(use_rs2 && rs2_f >= 5'(NREGS)) &&
                     !(use_rd  && rd_f  >= 5'(NREGS));
  end

  assign legal = op_ok && regs_ok;

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'd0:    alu_ctrl = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'd2:    alu_ctrl = ALU_SLT;
        3'd6:    alu_ctrl = ALU_OR;
        3'd7:    alu_ctrl = ALU_AND;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else if (opcode == OPC_BRANCH) begin
      alu_ctrl = ALU_SUB;
    end
  end

  assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? b_q : imm_q;

  always_comb begin
    case (alu_ctrl)
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
      default: alu_y = a_q + alu_b;
    endcase
  end

  // jal links in EXECUTE while the PC still points at the jal itself.
  assign rf_we    = (state == S_WB) || (state == S_EXECUTE && opcode == OPC_JAL);
  assign rf_wdata = (state == S_EXECUTE) ? pc + XLEN'(4) :
                    (opcode == OPC_LOAD) ? mdr_q : alu_q;

  rv_regfile_mc #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs1_f[AW-1:0]),
    .raddr_b (rs2_f[AW-1:0]),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .we      (rf_we),
    .waddr   (rd_f[AW-1:0]),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      target_q  <= '0;
      addr_q    <= '0;
      mdr_q     <= '0;
      alu_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata[31:0];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= rs1_data;
          b_q      <= rs2_data;
          imm_q    <= imm_val;
          target_q <= pc + imm_val;
          if (!legal) begin
            state     <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_q <= alu_y;
          case (opcode)
            OPC_LOAD, OPC_STORE: begin
              addr_q <= alu_y;
              state  <= S_MEM;
            end
            OPC_BRANCH: begin
              pc    <= (alu_y == '0) ? target_q : pc + XLEN'(4);
              state <= S_FETCH;
            end
            OPC_JAL: begin
              pc    <= target_q;
              state <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode == OPC_LOAD) begin
              mdr_q <= mem_rdata;
              state <= S_WB;
            end else begin
              pc    <= pc + XLEN'(4);
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          pc    <= pc + XLEN'(4);
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Reset gates the request directly so an in-flight transfer is abandoned at once.
  assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = !rst && (state == S_MEM) && (opcode == OPC_STORE);
  assign mem_addr  = (state == S_MEM) ? addr_q : pc;
  assign mem_wdata = b_q;

  assign instr_retired = (state == S_WB) ||
                         (state == S_EXECUTE && (opcode == OPC_BRANCH || opcode == OPC_JAL)) ||
                         (state == S_MEM && opcode == OPC_STORE && mem_ready);
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_rv_multi_cycle_core.sv
// Self-checking bench: an ISA-level reference model predicts each instruction's
// memory traffic, latency and retire/halt behaviour under random wait states.
module tb_rv_multi_cycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        instr_retired, halted, illegal;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] m_regs  [32];
  logic [31:0] m_pc;
  bit          m_halted;

  rv_multi_cycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instr_retired (instr_retired),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Random legal instruction; only forward control flow so a program always ends.
  function automatic logic [31:0] genInstr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] r;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 7))
      0, 1: case ($urandom_range(0, 4))
              0:       r = encR(7'h00, rs2, rs1, 3'd0, rd);
              1:       r = encR(7'h20, rs2, rs1, 3'd0, rd);
              2:       r = encR(7'h00, rs2, rs1, 3'd7, rd);
              3:       r = encR(7'h00, rs2, rs1, 3'd6, rd);
              default: r = encR(7'h00, rs2, rs1, 3'd2, rd);
            endcase
      2, 3: case ($urandom_range(0, 3))
              0:       r = encI(imm, rs1, 3'd0, rd, 7'b0010011);
              1:       r = encI(imm, rs1, 3'd7, rd, 7'b0010011);
              2:       r = encI(imm, rs1, 3'd6, rd, 7'b0010011);
              default: r = encI(imm, rs1, 3'd2, rd, 7'b0010011);
            endcase
      4:       r = encI(12'(32'h200 + 4 * $urandom_range(0, 63)), 5'd0, 3'd2, rd, 7'b0000011);
      5:       r = encS(12'(32'h200 + 4 * $urandom_range(0, 63)), rs2, 5'd0);
      6:       r = encB(13'(4 * $urandom_range(1, 2)), rs2, rs1);
      default: r = encJ(21'(4 * $urandom_range(1, 2)), rd);
    endcase
    return r;
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("rst_req_low", mem_req, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_fetch_req", mem_req, 1'b1);
    checkOutput("rst_fetch_addr", mem_addr, 32'h0);
    checkOutput("rst_fetch_we", mem_we, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_illegal", illegal, 1'b0);
    checkOutput("rst_retired", instr_retired, 1'b0);
    m_pc = 32'h0;
    m_halted = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // Executes one instruction in the model, then drives the DUT through it with
  // wf fetch wait cycles and wm data wait cycles, checking every transfer.
  task automatic applyStimulus(input int wf, input int wm);
    logic [31:0] ins, a, b, immI, immS, immB, immJ, res, nxt, dAddr, dData, pcNow;
    logic [31:0] pAddr, pWdata;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    bit          legal, wr, hasData, dWe, done, pStall, pReq, pWe;
    int          base, cyc, waitCnt, phase, want;

    pcNow = m_pc;
    ins  = ref_mem[m_pc[9:2]];
    op   = ins[6:0];
    rd   = ins[11:7];
    f3   = ins[14:12];
    rs1  = ins[19:15];
    rs2  = ins[24:20];
    f7   = ins[31:25];
    immI = {{20{ins[31]}}, ins[31:20]};
    immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    a = m_regs[rs1];
    b = m_regs[rs2];
    legal = 1'b1; wr = 1'b0; hasData = 1'b0; dWe = 1'b0;
    res = '0; dAddr = '0; dData = '0; nxt = m_pc + 4; base = 4;
    case (op)
      7'b0110011: begin
        wr = 1'b1;
        if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
        else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
        else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
        else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
        else if (f7 == 7'h00 && f3 == 3'd2) res = 32'($signed(a) < $signed(b));
        else legal = 1'b0;
      end
      7'b0010011: begin
        wr = 1'b1;
        case (f3)
          3'd0:    res = a + immI;
          3'd7:    res = a & immI;
          3'd6:    res = a | immI;
          3'd2:    res = 32'($signed(a) < $signed(immI));
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        if (f3 == 3'd2) begin
          hasData = 1'b1; dAddr = a + immI; res = ref_mem[dAddr[9:2]]; wr = 1'b1; base = 5;
        end else legal = 1'b0;
      end
      7'b0100011: begin
        if (f3 == 3'd2) begin
          hasData = 1'b1; dWe = 1'b1; dAddr = a + immS; dData = b;
        end else legal = 1'b0;
      end
      7'b1100011: begin
        base = 3;
        if (f3 != 3'd0) legal = 1'b0;
        else if (a == b) nxt = m_pc + immB;
      end
      7'b1101111: begin
        base = 3; wr = 1'b1; res = m_pc + 4; nxt = m_pc + immJ;
      end
      default: legal = 1'b0;
    endcase

    cyc = 0; waitCnt = 0; phase = 0; done = 1'b0; pStall = 1'b0;
    pReq = 1'b0; pWe = 1'b0; pAddr = '0; pWdata = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      want = (phase == 0) ? wf : wm;
      mem_ready = mem_req ? (waitCnt >= want) : 1'($urandom_range(0, 1));
      mem_rdata = (mem_req && !mem_we) ? mem[mem_addr[9:2]] : $urandom;
      #1;
      if (pStall) begin
        checkOutput("hold_req", mem_req, pReq);
        checkOutput("hold_we", mem_we, pWe);
        checkOutput("hold_addr", mem_addr, pAddr);
        if (pWe) checkOutput("hold_wdata", mem_wdata, pWdata);
      end
      pStall = mem_req && !mem_ready;
      pReq = mem_req; pWe = mem_we; pAddr = mem_addr; pWdata = mem_wdata;
      if (mem_req && mem_ready) begin
        if (phase == 0) begin
          checkOutput("fetch_addr", mem_addr, pcNow);
          checkOutput("fetch_we", mem_we, 1'b0);
        end else begin
          checkOutput("data_addr", mem_addr, dAddr);
          checkOutput("data_we", mem_we, dWe);
          if (mem_we) begin
            checkOutput("store_data", mem_wdata, dData);
            mem[mem_addr[9:2]] = mem_wdata;
          end
        end
        phase++;
        waitCnt = 0;
      end else if (mem_req) begin
        waitCnt++;
      end
      if (instr_retired || halted) done = 1'b1;
    end

    if (legal) begin
      checkOutput("xfer_count", phase, hasData ? 2 : 1);
      checkOutput("retire", instr_retired, 1'b1);
      checkOutput("latency", cyc, base + wf + (hasData ? wm : 0));
      checkOutput("not_halted", halted, 1'b0);
      if (wr && rd != 5'd0) m_regs[rd] = res;
      if (dWe) ref_mem[dAddr[9:2]] = dData;
      m_pc = nxt;
    end else begin
      checkOutput("halt_xfer_count", phase, 1);
      checkOutput("halted", halted, 1'b1);
      checkOutput("illegal", illegal, 1'b1);
      checkOutput("halt_no_retire", instr_retired, 1'b0);
      checkOutput("halt_latency", cyc, 3 + wf);
      m_halted = 1'b1;
    end
  endtask

  task automatic checkHaltIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      checkOutput("idle_req", mem_req, 1'b0);
      checkOutput("idle_retire", instr_retired, 1'b0);
      checkOutput("idle_halted", halted, 1'b1);
      checkOutput("idle_illegal", illegal, 1'b1);
    end
  endtask

  task automatic loadWord(input int idx, input logic [31:0] w);
    mem[idx] = w;
    ref_mem[idx] = w;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) loadWord(i, (i >= 128) ? $urandom : 32'h0);

    // Program A: addi, add, sw, lw, then beq x1,x1,-4 looping back onto the lw.
    loadWord(0, 32'h00500093);
    loadWord(1, 32'h00108133);
    loadWord(2, 32'h00202423);
    loadWord(3, 32'h00802183);
    loadWord(4, 32'hFE108EE3);
    applyReset();
    $display("[TB] zero-wait sequence");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0);
    $display("[TB] wait-state sequence");
    applyStimulus(3, 3);
    applyStimulus(3, 0);

    // Stall the lw data phase at 0x0C and reset in the middle of it.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = mem[mem_addr[9:2]];
    #1 checkOutput("pre_rst_fetch_addr", mem_addr, 32'hC);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (mem_req) found = 1'b1;
    end
    checkOutput("mid_mem_req_seen", found, 1'b1);
    checkOutput("mid_mem_addr", mem_addr, 32'h8);
    rst = 1'b1;
    #1 checkOutput("rst_drops_req", mem_req, 1'b0);

    // Program B: beq x1,x2 not taken falls through to an all-zero word.
    loadWord(0, 32'h00500093);
    loadWord(1, 32'h00108133);
    loadWord(2, 32'h00000013);
    loadWord(3, 32'h00000013);
    loadWord(4, 32'hFE208EE3);
    loadWord(5, 32'h00000000);
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 0);
    checkHaltIdle(4);

    $display("[TB] random program");
    for (int i = 0; i < 128; i++) loadWord(i, (i < 50) ? genInstr() : 32'h0);
    applyReset();
    for (int i = 0; i < 80 && !m_halted; i++)
      applyStimulus($urandom_range(0, 2), $urandom_range(0, 2));
    checkOutput("random_reached_halt", m_halted, 1'b1);
    checkHaltIdle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
